// File: rtl/best_1ofn_busy_pipe.sv
// rtl/best_1ofn_busy_pipe.sv - pipelined best-1-of-N pattern selector; sub-strip key enabled by BEST_1OFN_SUBKEY_EN
`timescale 1ns/1ps
module best_1ofn_busy_pipe #(
    parameter int NCH     = 7,
    parameter int PAT_W   = 7,
    parameter int KEY_W   = 5,
    parameter int CARRY_W = 12,
    parameter int OFFS_W  = 4,
    localparam int CH_W   = $clog2(NCH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [NCH*PAT_W-1:0]      pat,
    input  logic [NCH*KEY_W-1:0]      key,
    input  logic [NCH*CARRY_W-1:0]    carry,
    input  logic [NCH*OFFS_W-1:0]     offs,
    input  logic [NCH-1:0]            bsy,
    output logic                      valid_out,
    output logic [PAT_W-1:0]          best_pat,
    output logic [CH_W+KEY_W-1:0]     best_key,
    output logic [CARRY_W-1:0]        best_carry,
    output logic [CH_W+KEY_W+1:0]     best_subkey,
    output logic                      best_bsy
);
    localparam int L     = $clog2(NCH);
    localparam int SK_W  = CH_W + KEY_W + 2;
    localparam int SUM_W = ((SK_W > OFFS_W) ? SK_W : OFFS_W) + 2;
    localparam logic [SUM_W-1:0] SK_MAX = SUM_W'(4 * NCH * (2 ** KEY_W) - 1);

    // Number of live candidates at tree level l (level 0 = registered inputs).
    function automatic int level_cnt(input int l);
        return (NCH + (1 << l) - 1) >> l;
    endfunction

    logic [L:0]         t_valid;
    logic [PAT_W-1:0]   t_pat   [0:L][0:NCH-1];
    logic [PAT_W-1:0]   n_pat   [0:L][0:NCH-1];
    logic [KEY_W-1:0]   t_key   [0:L][0:NCH-1];
    logic [KEY_W-1:0]   n_key   [0:L][0:NCH-1];
    logic [CARRY_W-1:0] t_carry [0:L][0:NCH-1];
    logic [CARRY_W-1:0] n_carry [0:L][0:NCH-1];
    logic [CH_W-1:0]    t_idx   [0:L][0:NCH-1];
    logic [CH_W-1:0]    n_idx   [0:L][0:NCH-1];
    logic [NCH-1:0]     t_elig  [0:L];
    logic [NCH-1:0]     n_elig  [0:L];
`ifdef BEST_1OFN_SUBKEY_EN
    logic [OFFS_W-1:0]  t_offs  [0:L][0:NCH-1];
    logic [OFFS_W-1:0]  n_offs  [0:L][0:NCH-1];
    logic signed [SUM_W-1:0] sk_sum;
`else
    logic unused_offs;
    assign unused_offs = ^offs;
`endif

    int   a;
    int   b;
    logic take_b;

    always_comb begin
        a      = 0;
        b      = 0;
        take_b = 1'b0;
        for (int l = 0; l <= L; l++) begin
            n_elig[l] = '0;
            for (int j = 0; j < NCH; j++) begin
                n_pat[l][j]   = '0;
                n_key[l][j]   = '0;
                n_carry[l][j] = '0;
                n_idx[l][j]   = '0;
`ifdef BEST_1OFN_SUBKEY_EN
                n_offs[l][j]  = '0;
`endif
            end
        end
        for (int i = 0; i < NCH; i++) begin
            n_pat[0][i]   = pat[i*PAT_W +: PAT_W];
            n_key[0][i]   = key[i*KEY_W +: KEY_W];
            n_carry[0][i] = carry[i*CARRY_W +: CARRY_W];
            n_idx[0][i]   = CH_W'(i);
            n_elig[0][i]  = !bsy[i];
`ifdef BEST_1OFN_SUBKEY_EN
            n_offs[0][i]  = offs[i*OFFS_W +: OFFS_W];
`endif
        end
        // An odd last node pairs with itself; B never strictly beats itself, so it passes through.
        for (int l = 1; l <= L; l++) begin
            for (int j = 0; j < NCH; j++) begin
                if (j < level_cnt(l)) begin
                    a = 2 * j;
                    b = (2 * j + 1 < level_cnt(l - 1)) ? 2 * j + 1 : 2 * j;
                    take_b = t_elig[l-1][b] &&
                             (!t_elig[l-1][a] ||
                              (t_pat[l-1][b][PAT_W-1:1] > t_pat[l-1][a][PAT_W-1:1]));
                    n_pat[l][j]   = take_b ? t_pat[l-1][b]   : t_pat[l-1][a];
                    n_key[l][j]   = take_b ? t_key[l-1][b]   : t_key[l-1][a];
                    n_carry[l][j] = take_b ? t_carry[l-1][b] : t_carry[l-1][a];
                    n_idx[l][j]   = take_b ? t_idx[l-1][b]   : t_idx[l-1][a];
                    n_elig[l][j]  = t_elig[l-1][a] | t_elig[l-1][b];
`ifdef BEST_1OFN_SUBKEY_EN
                    n_offs[l][j]  = take_b ? t_offs[l-1][b]  : t_offs[l-1][a];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_valid <= '0;
            for (int l = 0; l <= L; l++) begin
                t_elig[l] <= '0;
                for (int j = 0; j < NCH; j++) begin
                    t_pat[l][j]   <= '0;
                    t_key[l][j]   <= '0;
                    t_carry[l][j] <= '0;
                    t_idx[l][j]   <= '0;
`ifdef BEST_1OFN_SUBKEY_EN
                    t_offs[l][j]  <= '0;
`endif
                end
            end
        end else begin
            t_valid <= {t_valid[L-1:0], valid_in};
            t_pat   <= n_pat;
            t_key   <= n_key;
            t_carry <= n_carry;
            t_idx   <= n_idx;
            t_elig  <= n_elig;
`ifdef BEST_1OFN_SUBKEY_EN
            t_offs  <= n_offs;
`endif
        end
    end

    // Output stage is combinational off the root register so latency stays 1+L.
    always_comb begin
        valid_out   = 1'b0;
        best_pat    = '0;
        best_key    = '0;
        best_carry  = '0;
        best_subkey = '0;
        best_bsy    = 1'b0;
`ifdef BEST_1OFN_SUBKEY_EN
        sk_sum      = '0;
`endif
        if (t_valid[L]) begin
            valid_out = 1'b1;
            if (t_elig[L][0]) begin
                best_pat   = t_pat[L][0];
                best_key   = {t_idx[L][0], t_key[L][0]};
                best_carry = t_carry[L][0];
`ifdef BEST_1OFN_SUBKEY_EN
                sk_sum = $signed({{(SUM_W-SK_W){1'b0}}, t_idx[L][0], t_key[L][0], 2'b00}) +
                         $signed({{(SUM_W-OFFS_W){t_offs[L][0][OFFS_W-1]}}, t_offs[L][0]});
                if (sk_sum[SUM_W-1])
                    best_subkey = '0;
                else if (sk_sum > $signed(SK_MAX))
                    best_subkey = SK_MAX[SK_W-1:0];
                else
                    best_subkey = sk_sum[SK_W-1:0];
`endif
            end else begin
                best_bsy = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_best_1ofn_busy_pipe.sv
// tb/tb_best_1ofn_busy_pipe.sv - self-checking bench for best_1ofn_busy_pipe (model + directed vectors)
`timescale 1ns/1ps
module tb_best_1ofn_busy_pipe;
    localparam int NCH = 7, PAT_W = 7, KEY_W = 5, CARRY_W = 12, OFFS_W = 4, CH_W = 3;
    localparam int LAT = 4;
    localparam int SK_W = CH_W + KEY_W + 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   valid_in;
    logic [NCH*PAT_W-1:0]   pat;
    logic [NCH*KEY_W-1:0]   key;
    logic [NCH*CARRY_W-1:0] carry;
    logic [NCH*OFFS_W-1:0]  offs;
    logic [NCH-1:0]         bsy;
    logic                   valid_out;
    logic [PAT_W-1:0]       best_pat;
    logic [CH_W+KEY_W-1:0]  best_key;
    logic [CARRY_W-1:0]     best_carry;
    logic [SK_W-1:0]        best_subkey;
    logic                   best_bsy;

    best_1ofn_busy_pipe dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .pat(pat), .key(key), .carry(carry), .offs(offs), .bsy(bsy),
        .valid_out(valid_out), .best_pat(best_pat), .best_key(best_key),
        .best_carry(best_carry), .best_subkey(best_subkey), .best_bsy(best_bsy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic                  v;
        logic [PAT_W-1:0]      p;
        logic [CH_W+KEY_W-1:0] k;
        logic [CARRY_W-1:0]    c;
        logic [SK_W-1:0]       sk;
        logic                  b;
    } res_t;

    res_t mdl [LAT];
    int   checks = 0;
    int   failures = 0;
    logic cmp_en = 1'b0;

    function automatic res_t mk(input logic v, input logic [PAT_W-1:0] p, input int k,
                                input logic [CARRY_W-1:0] c, input int sk, input logic b);
        res_t r;
        r.v = v; r.p = p; r.k = (CH_W+KEY_W)'(k); r.c = c; r.sk = SK_W'(sk); r.b = b;
        return r;
    endfunction

    // Winner = highest pat[6:1] among non-busy channels, lowest index on ties.
    function automatic res_t predict();
        res_t r;
        int   w;
        int   s;
        r = '0;
        w = -1;
        s = 0;
        if (!valid_in) return r;
        r.v = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (!bsy[i] && (w < 0 || pat[i*PAT_W+1 +: PAT_W-1] > pat[w*PAT_W+1 +: PAT_W-1]))
                w = i;
        if (w < 0) begin
            r.b = 1'b1;
        end else begin
            r.p = pat[w*PAT_W +: PAT_W];
            r.k = (CH_W+KEY_W)'(w * 32 + int'(key[w*KEY_W +: KEY_W]));
            r.c = carry[w*CARRY_W +: CARRY_W];
`ifdef BEST_1OFN_SUBKEY_EN
            s = 4 * (w * 32 + int'(key[w*KEY_W +: KEY_W])) + int'($signed(offs[w*OFFS_W +: OFFS_W]));
            if (s < 0) s = 0;
            if (s > 4 * NCH * 32 - 1) s = 4 * NCH * 32 - 1;
`endif
            r.sk = SK_W'(s);
        end
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) mdl[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = predict();
        end
    end

    always @(negedge clock) begin
        res_t got;
        if (cmp_en) begin
            got = {valid_out, best_pat, best_key, best_carry, best_subkey, best_bsy};
            checks++;
            if (got !== mdl[LAT-1]) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, mdl[LAT-1]);
            end
        end
    end

    task automatic chk(input string nm, input res_t exp);
        res_t got;
        got = {valid_out, best_pat, best_key, best_carry, best_subkey, best_bsy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic clr_inputs();
        valid_in = 1'b0; pat = '0; key = '0; carry = '0; offs = '0; bsy = '0;
    endtask

    // Sort keys {1,2,3,9,4,5,6}; ch3 pat 7'h13 (bend set); key = 10+i, carry = A00+i.
    task automatic base_set();
        int sorts [NCH];
        sorts = '{1, 2, 3, 9, 4, 5, 6};
        for (int i = 0; i < NCH; i++) begin
            pat[i*PAT_W +: PAT_W]       = PAT_W'(sorts[i] * 2);
            key[i*KEY_W +: KEY_W]       = KEY_W'(10 + i);
            carry[i*CARRY_W +: CARRY_W] = CARRY_W'(12'hA00 + i);
            offs[i*OFFS_W +: OFFS_W]    = '0;
        end
        pat[3*PAT_W +: PAT_W] = 7'h13;
        bsy = '0;
    endtask

    // Called at a negedge with a set on the inputs; returns at the negedge where its result shows.
    task automatic run_single();
        valid_in = 1'b1;
        @(negedge clock);
        clr_inputs();
        repeat (LAT - 1) @(negedge clock);
    endtask

    task automatic rand_set();
        valid_in = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            pat[i*PAT_W +: PAT_W]       = PAT_W'($urandom_range(0, 15));
            key[i*KEY_W +: KEY_W]       = KEY_W'($urandom);
            carry[i*CARRY_W +: CARRY_W] = CARRY_W'($urandom);
            offs[i*OFFS_W +: OFFS_W]    = OFFS_W'($urandom);
        end
        bsy = ($urandom_range(0, 5) == 0) ? 7'h7F : NCH'($urandom);
    endtask

    int sk1, sk2, sk3;
    int nvalid;

    initial begin
`ifdef BEST_1OFN_SUBKEY_EN
        sk1 = 436; sk2 = 304; sk3 = 832;
`else
        sk1 = 0; sk2 = 0; sk3 = 0;
`endif
        reset = 1'b1;
        clr_inputs();
        repeat (3) @(negedge clock);
        chk("reset_state", mk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clock);

        base_set();
        run_single();
        chk("max_ch3", mk(1, 7'h13, 109, 12'hA03, sk1, 0));

        base_set();
        pat[0 +: NCH*PAT_W] = {7'h0A, 7'h15, 7'h08, 7'h06, 7'h14, 7'h04, 7'h02};
        run_single();
        chk("tie_low_index", mk(1, 7'h14, 76, 12'hA02, sk2, 0));

        base_set();
        bsy = 7'h08;
        run_single();
        chk("busy_skip_ch6", mk(1, 7'h0C, 208, 12'hA06, sk3, 0));

        base_set();
        bsy = 7'h7F;
        run_single();
        chk("all_busy", mk(1, 0, 0, 0, 0, 1));

`ifdef BEST_1OFN_SUBKEY_EN
        base_set();
        bsy = 7'h7E;
        key[0 +: KEY_W] = '0;
        offs[0 +: OFFS_W] = 4'hD;
        run_single();
        chk("subkey_clamp_low", mk(1, 7'h02, 0, 12'hA00, 0, 0));

        base_set();
        bsy = 7'h3F;
        key[6*KEY_W +: KEY_W] = 5'd31;
        offs[6*OFFS_W +: OFFS_W] = 4'd7;
        run_single();
        chk("subkey_clamp_high", mk(1, 7'h0C, 223, 12'hA06, 895, 0));
`endif

        nvalid = 0;
        for (int k = 0; k < 14; k++) begin
            if (k >= LAT) nvalid += int'(valid_out);
            rand_set();
            @(negedge clock);
        end
        checks++;
        if (nvalid != 10) begin
            failures++;
            $display("FAIL stream_valid_count got=%0d exp=10", nvalid);
        end

        reset = 1'b1;
        rand_set();
        @(negedge clock);
        chk("reset_midstream", mk(0, 0, 0, 0, 0, 0));
        rand_set();
        @(negedge clock);
        reset = 1'b0;
        clr_inputs();
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("no_stale_after_reset", mk(0, 0, 0, 0, 0, 0));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
